// File: rtl/suma_pipe_flags_if.sv
// Operand/result handshake bundle for the pipelined NZCV adder/subtractor.
// The master drives operands and takes results; the slave is the adder pipeline.
interface suma_pipe_flags_if #(
    parameter int M = 8
);
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] r;
    logic         c;
    logic         n;
    logic         v;
    logic         z;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, r, c, n, v, z
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, r, c, n, v, z
    );
endinterface

// File: rtl/suma_pipe_flags.sv
// Pipelined M-bit add/sub with NZCV flags: one CHUNK-bit slice per stage, with the
// carry registered between stages and a global stall driven by output backpressure.
module suma_pipe_flags #(
    parameter int M     = 8,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    suma_pipe_flags_if.slave     bus
);
    localparam int STAGES = M / CHUNK;

    logic         stall_s;
    logic         out_valid_r;
    logic [M-1:0] r_r;
    logic         c_r;
    logic         n_r;
    logic         v_r;
    logic         z_r;

    assign stall_s       = out_valid_r & ~bus.out_ready;
    assign bus.in_ready  = ~stall_s;
    assign bus.out_valid = out_valid_r;
    assign bus.r         = r_r;
    assign bus.c         = c_r;
    assign bus.n         = n_r;
    assign bus.v         = v_r;
    assign bus.z         = z_r;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * CHUNK;
        // operand bits still to be added when entering this stage
        localparam int HW = M - LO;

        logic [HW-1:0]         a_in_s;
        logic [HW-1:0]         b_in_s;
        logic                  op_in_s;
        logic                  cin_s;
        logic                  vin_s;
        logic [CHUNK-1:0]      b_eff_s;
        logic [CHUNK:0]        sum_s;
        logic [LO+CHUNK-1:0]   res_nxt_s;

        if (k == 0) begin : g_src
            assign a_in_s    = bus.a;
            assign b_in_s    = bus.b;
            assign op_in_s   = bus.op;
            assign cin_s     = bus.op;
            assign vin_s     = bus.in_valid;
            assign res_nxt_s = sum_s[CHUNK-1:0];
        end else begin : g_src
            assign a_in_s    = g_stg[k-1].g_mid.a_hi_r;
            assign b_in_s    = g_stg[k-1].g_mid.b_hi_r;
            assign op_in_s   = g_stg[k-1].g_mid.op_r;
            assign cin_s     = g_stg[k-1].g_mid.carry_r;
            assign vin_s     = g_stg[k-1].g_mid.valid_r;
            assign res_nxt_s = {sum_s[CHUNK-1:0], g_stg[k-1].g_mid.res_r};
        end

        assign b_eff_s = op_in_s ? ~b_in_s[CHUNK-1:0] : b_in_s[CHUNK-1:0];
        assign sum_s   = {1'b0, a_in_s[CHUNK-1:0]} + {1'b0, b_eff_s} + {{CHUNK{1'b0}}, cin_s};

        if (k < STAGES - 1) begin : g_mid
            logic [HW-CHUNK-1:0] a_hi_r;
            logic [HW-CHUNK-1:0] b_hi_r;
            logic [LO+CHUNK-1:0] res_r;
            logic                op_r;
            logic                carry_r;
            logic                valid_r;

            // Intermediate stage register: finished low slices, pending high operands, carry/op/valid.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_hi_r  <= '0;
                    b_hi_r  <= '0;
                    res_r   <= '0;
                    op_r    <= 1'b0;
                    carry_r <= 1'b0;
                    valid_r <= 1'b0;
                end else if (!stall_s) begin
                    a_hi_r  <= a_in_s[HW-1:CHUNK];
                    b_hi_r  <= b_in_s[HW-1:CHUNK];
                    res_r   <= res_nxt_s;
                    op_r    <= op_in_s;
                    carry_r <= sum_s[CHUNK];
                    valid_r <= vin_s;
                end
            end
        end else begin : g_last
            logic carry_msb_s;

            // carry into bit M-1 recovered from the MSB sum bit: s = a ^ b ^ cin
            assign carry_msb_s = a_in_s[CHUNK-1] ^ b_eff_s[CHUNK-1] ^ sum_s[CHUNK-1];

            // Output stage: result and NZCV update only when a finished beat arrives.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid_r <= 1'b0;
                    r_r         <= '0;
                    c_r         <= 1'b0;
                    n_r         <= 1'b0;
                    v_r         <= 1'b0;
                    z_r         <= 1'b0;
                end else if (!stall_s) begin
                    out_valid_r <= vin_s;
                    if (vin_s) begin
                        r_r <= res_nxt_s;
                        c_r <= sum_s[CHUNK];
                        n_r <= sum_s[CHUNK-1];
                        v_r <= carry_msb_s ^ sum_s[CHUNK];
                        z_r <= ~|res_nxt_s;
                    end
                end
            end
        end
    end
endmodule
